// File: rtl/perf_latency_stats.sv
// Latency statistics engine: consumes latency samples from the monitor FIFO,
// keeps live count/min/max/sum/histogram and publishes a coherent snapshot.
module perf_latency_stats #(
  parameter int LAT_WIDTH = 31,
  parameter int CNT_WIDTH = 32,
  parameter int SUM_WIDTH = 48,
  parameter int NUM_BINS  = 8,
  parameter int BIN_SHIFT = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [LAT_WIDTH-1:0]          sample_i,
  input  logic                          sample_valid_i,
  output logic                          sample_ready_o,
  input  logic                          clear_i,
  input  logic                          snap_i,
  output logic                          snap_valid_o,
  output logic [CNT_WIDTH-1:0]          count_o,
  output logic [LAT_WIDTH-1:0]          min_o,
  output logic [LAT_WIDTH-1:0]          max_o,
  output logic [SUM_WIDTH-1:0]          sum_o,
  output logic                          sum_sat_o,
  output logic [NUM_BINS*CNT_WIDTH-1:0] hist_o
);

  localparam int BIN_W = $clog2(NUM_BINS);

  typedef enum logic {ST_RUN, ST_CLEAR} state_t;

  state_t                 state_reg, state_next;
  logic                   s1_valid_reg;
  logic [LAT_WIDTH-1:0]   s1_data_reg;
  logic                   accept;

  // live statistics and their post-update values
  logic [CNT_WIDTH-1:0]   cnt_reg, cnt_upd;
  logic [LAT_WIDTH-1:0]   min_reg, min_upd;
  logic [LAT_WIDTH-1:0]   max_reg, max_upd;
  logic [SUM_WIDTH-1:0]   sum_reg, sum_upd;
  logic                   sat_reg, sat_upd;
  logic [CNT_WIDTH-1:0]   hist_reg [NUM_BINS];
  logic [CNT_WIDTH-1:0]   hist_upd [NUM_BINS];

  // snapshot registers seen by the register map
  logic                   snap_pend_reg;
  logic                   snap_valid_reg;
  logic [CNT_WIDTH-1:0]   snap_cnt_reg;
  logic [LAT_WIDTH-1:0]   snap_min_reg;
  logic [LAT_WIDTH-1:0]   snap_max_reg;
  logic [SUM_WIDTH-1:0]   snap_sum_reg;
  logic                   snap_sat_reg;
  logic [CNT_WIDTH-1:0]   snap_hist_reg [NUM_BINS];

  logic [SUM_WIDTH:0]     sum_wide;
  logic [LAT_WIDTH-1:0]   bin_raw;
  logic [BIN_W-1:0]       bin_idx;

  // No accept in the clear_i cycle keeps stage 1 empty while in CLEAR.
  assign sample_ready_o = (state_reg == ST_RUN) && !clear_i;
  assign accept         = sample_valid_i && sample_ready_o;

  assign sum_wide = {1'b0, sum_reg} + {{(SUM_WIDTH + 1 - LAT_WIDTH){1'b0}}, s1_data_reg};
  assign bin_raw  = s1_data_reg >> BIN_SHIFT;
  assign bin_idx  = (bin_raw > LAT_WIDTH'(NUM_BINS - 1)) ? BIN_W'(NUM_BINS - 1)
                                                         : bin_raw[BIN_W-1:0];

  // FSM state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_reg <= ST_RUN;
    else         state_reg <= state_next;
  end

  // FSM next state: CLEAR lasts exactly one cycle, clear_i inside it is ignored
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_RUN:   if (clear_i) state_next = ST_CLEAR;
      ST_CLEAR: state_next = ST_RUN;
      default:  state_next = ST_RUN;
    endcase
  end

  // Stage 1: register the accepted sample
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_valid_reg <= 1'b0;
      s1_data_reg  <= '0;
    end else begin
      s1_valid_reg <= accept;
      if (accept) s1_data_reg <= sample_i;
    end
  end

  // Scalar statistics after folding in the stage-1 sample (clear not applied)
  always_comb begin
    cnt_upd = cnt_reg;
    min_upd = min_reg;
    max_upd = max_reg;
    sum_upd = sum_reg;
    sat_upd = sat_reg;
    if (s1_valid_reg) begin
      if (cnt_reg != '1) cnt_upd = cnt_reg + 1'b1;
      if (s1_data_reg < min_reg) min_upd = s1_data_reg;
      if (s1_data_reg > max_reg) max_upd = s1_data_reg;
      if (sum_wide[SUM_WIDTH]) begin
        sum_upd = '1;
        sat_upd = 1'b1;
      end else begin
        sum_upd = sum_wide[SUM_WIDTH-1:0];
      end
    end
  end

  // Per-bin saturating increment and flattened snapshot output
  for (genvar gi = 0; gi < NUM_BINS; gi++) begin : g_bin
    assign hist_upd[gi] = (s1_valid_reg && (bin_idx == BIN_W'(gi)) && (hist_reg[gi] != '1))
                          ? hist_reg[gi] + 1'b1 : hist_reg[gi];
    assign hist_o[gi*CNT_WIDTH +: CNT_WIDTH] = snap_hist_reg[gi];
  end

  // Live statistics: load reset values when leaving CLEAR, otherwise update
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_reg <= '0;
      min_reg <= '1;
      max_reg <= '0;
      sum_reg <= '0;
      sat_reg <= 1'b0;
      for (int i = 0; i < NUM_BINS; i++) hist_reg[i] <= '0;
    end else if (state_reg == ST_CLEAR) begin
      cnt_reg <= '0;
      min_reg <= '1;
      max_reg <= '0;
      sum_reg <= '0;
      sat_reg <= 1'b0;
      for (int i = 0; i < NUM_BINS; i++) hist_reg[i] <= '0;
    end else begin
      cnt_reg <= cnt_upd;
      min_reg <= min_upd;
      max_reg <= max_upd;
      sum_reg <= sum_upd;
      sat_reg <= sat_upd;
      for (int i = 0; i < NUM_BINS; i++) hist_reg[i] <= hist_upd[i];
    end
  end

  // Snapshot capture one cycle after snap_i; a repeat snap_i while pending merges
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      snap_pend_reg  <= 1'b0;
      snap_valid_reg <= 1'b0;
      snap_cnt_reg   <= '0;
      snap_min_reg   <= '1;
      snap_max_reg   <= '0;
      snap_sum_reg   <= '0;
      snap_sat_reg   <= 1'b0;
      for (int i = 0; i < NUM_BINS; i++) snap_hist_reg[i] <= '0;
    end else begin
      snap_pend_reg  <= snap_i && !snap_pend_reg;
      snap_valid_reg <= snap_pend_reg;
      if (snap_pend_reg) begin
        snap_cnt_reg <= cnt_upd;
        snap_min_reg <= min_upd;
        snap_max_reg <= max_upd;
        snap_sum_reg <= sum_upd;
        snap_sat_reg <= sat_upd;
        for (int i = 0; i < NUM_BINS; i++) snap_hist_reg[i] <= hist_upd[i];
      end
    end
  end

  assign snap_valid_o = snap_valid_reg;
  assign count_o      = snap_cnt_reg;
  assign min_o        = snap_min_reg;
  assign max_o        = snap_max_reg;
  assign sum_o        = snap_sum_reg;
  assign sum_sat_o    = snap_sat_reg;

endmodule
